mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit implementing the RV32M operations for the execute stage. Sits beside the single-cycle ALU: the decode stage routes M-extension instructions here with a start pulse, the pipeline stalls on `busy`, and the result is written back when `done` pulses. A shared shift/add datapath gives fixed latency for every operation, so it is small and simple to verify.

## Interface
- `XLEN`, 32, operand/result width (only 32 supported)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only while idle or on the `done` cycle
- `flush`  in  1  abort the in-flight operation (pipeline squash)
- `op`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `a`  in  32  rs1 operand, captured with `start`
- `b`  in  32  rs2 operand, captured with `start`
- `busy`  out  1  operation in flight; high while CALC
- `done`  out  1  one-cycle pulse, `result` valid in this cycle
- `result`  out  32  result register; holds its value until the next `done`

## Operation
- States: IDLE, CALC, DONE. Reset enters IDLE with `busy`=0, `done`=0, `result`=0, iteration counter=0.
- IDLE/DONE with `start`=1: capture `op`, `a`, `b` and go to CALC with counter=0. In DONE without `start`, go to IDLE.
- `start` while in CALC is ignored. Operands are not re-sampled.
- Signed operands (MULH: a,b; MULHSU: a only; DIV/REM: a,b) are converted to magnitude at capture. The result sign is recorded: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- Multiply: unsigned shift-add, 64-bit accumulator, one multiplier bit per cycle, 32 iterations. MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32], taken after the 64-bit two's-complement sign fix.
- Divide: restoring, 33-bit partial remainder, one quotient bit per cycle, 32 iterations. The quotient and remainder sign fixes are applied at finish.
- Special cases are resolved at finish, with latency unchanged:
  - b=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- CALC exits when counter reaches 31 after that iteration. The next edge writes `result` and enters DONE.
- `flush`=1 has priority over everything except reset:
  - In CALC: go to IDLE with no `done`; `result` unchanged.
  - In DONE: `done` still shows this cycle; a simultaneous `start` is dropped.
  - In IDLE: a simultaneous `start` is dropped.
- Asserting reset mid-operation clears all state immediately. No `done` follows.

## Timing
- Start accepted at edge E0. `busy`=1 during cycles after E0 through E32 (32 iterations at E1..E32).
- Result is registered at E33. `done`=1 and `busy`=0 during the cycle after E33. Fixed latency is 33 cycles from the accepting edge to `done`, for every op and operand value.
- Back-to-back: `start` in the DONE cycle is accepted at E34. `busy` rises the next cycle with no idle gap.
- `done` never stays high for more than one cycle. `busy` and `done` are never high together.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset then idle: hold `rst_n`=0, then release with `start`=0 → `busy`=0, `done`=0, `result`=0 for 10 cycles.
- Multiply set, each op followed by a `done` check exactly 33 cycles after acceptance:
  - MUL 7×6 → 42.
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- Divide set:
  - DIV −7/2 → 0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1).
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Corner cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - All with the same 33-cycle latency.
- Handshake:
  - `start` pulsed mid-CALC with different operands → ignored; first result correct.
  - `start` on the `done` cycle → second op accepted with no gap; both results correct.
- Abort: `flush` at cycle 10 of CALC → `busy` falls the next cycle, no `done` ever, `result` keeps its prior value. The same check with `rst_n` pulsed low mid-CALC → all outputs 0 immediately.

Source files
------------

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the execute stage and the iterative MDU.
interface mdu_iter_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, op, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit. One shared shift/add datapath, fixed
// 33-cycle latency from the accepting edge to the done pulse for every op.
module mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input logic       clk,
  input logic       rst_n,
  mdu_iter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e r_state, w_state_next;
  logic   w_accept;

  // Shared datapath: r_hi = product high half / partial remainder,
  // r_lo = multiplier / dividend shifting into quotient, r_opb = multiplicand / divisor.
  logic [XLEN-1:0] r_hi, r_lo, r_opb;
  logic [XLEN-1:0] r_a;
  logic [2:0]      r_op;
  logic [4:0]      r_cnt;
  logic            r_fin;    // all 32 iterations done, next CALC edge writes result
  logic            r_neg;    // product / quotient sign
  logic            r_rneg;   // remainder sign (follows dividend)
  logic            r_bzero;
  logic            r_ovf;
  logic [XLEN-1:0] r_result;

  logic            w_is_div, w_sa, w_sb;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0] w_quo, w_rem, w_res;

  assign bus.busy   = (r_state == StCalc);
  assign bus.done   = (r_state == StDone);
  assign bus.result = r_result;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state logic; flush overrides start and aborts CALC
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      StIdle: begin
        if (!bus.flush && bus.start) begin
          w_accept     = 1'b1;
          w_state_next = StCalc;
        end
      end
      StCalc: begin
        if (bus.flush)  w_state_next = StIdle;
        else if (r_fin) w_state_next = StDone;
      end
      StDone: begin
        if (!bus.flush && bus.start) begin
          w_accept     = 1'b1;
          w_state_next = StCalc;
        end else begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Operand sign handling at capture and one iteration of multiply/divide
  always_comb begin
    w_is_div = bus.op[2];
    w_sa     = bus.a[XLEN-1] & ((bus.op == 3'd1) | (bus.op == 3'd2) |
                                (bus.op == 3'd4) | (bus.op == 3'd6));
    w_sb     = bus.b[XLEN-1] & ((bus.op == 3'd1) | (bus.op == 3'd4) | (bus.op == 3'd6));
    w_mag_a  = w_sa ? -bus.a : bus.a;
    w_mag_b  = w_sb ? -bus.b : bus.b;

    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});

    w_shift = {r_hi, r_lo[XLEN-1]};
    w_ge    = (w_shift >= {1'b0, r_opb});
    // True difference fits XLEN bits whenever w_ge holds
    w_sub   = w_shift[XLEN-1:0] - r_opb;
  end

  // Final result selection with sign fixes and RISC-V special cases
  always_comb begin
    w_prod     = {r_hi, r_lo};
    w_prod_fix = r_neg ? -w_prod : w_prod;
    w_quo      = r_neg ? -r_lo : r_lo;
    w_rem      = r_rneg ? -r_hi : r_hi;
    w_res      = '0;
    case (r_op)
      3'd0:                w_res = w_prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    w_res = w_prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5: begin
        if (r_bzero)       w_res = '1;
        else if (r_ovf)    w_res = {1'b1, {(XLEN-1){1'b0}}};
        else               w_res = w_quo;
      end
      default: begin
        if (r_bzero)       w_res = r_a;
        else if (r_ovf)    w_res = '0;
        else               w_res = w_rem;
      end
    endcase
  end

  // Datapath registers: capture, iterate, then write result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_a      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_fin    <= 1'b0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_bzero  <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= bus.op;
      r_a     <= bus.a;
      r_bzero <= (bus.b == '0);
      r_ovf   <= ((bus.op == 3'd4) | (bus.op == 3'd6)) &&
                 (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
      r_neg   <= w_sa ^ w_sb;
      r_rneg  <= w_sa;
      r_hi    <= '0;
      r_lo    <= w_is_div ? w_mag_a : w_mag_b;
      r_opb   <= w_is_div ? w_mag_b : w_mag_a;
      r_cnt   <= '0;
      r_fin   <= 1'b0;
    end else if (r_state == StCalc && !bus.flush) begin
      if (!r_fin) begin
        if (r_op[2]) begin
          r_hi <= w_ge ? w_sub : w_shift[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], w_ge};
        end else begin
          r_hi <= w_mul_sum[XLEN:1];
          r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
        end
        if (r_cnt == 5'(XLEN - 1)) r_fin <= 1'b1;
        else                       r_cnt <= r_cnt + 5'd1;
      end else begin
        r_result <= w_res;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table through a result scoreboard,
// plus hand-written handshake, flush and reset sequences.
module tb_mdu_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_iter_if #(.XLEN(32)) bus ();

  mdu_iter #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] exp;
    int          acc;
    string       name;
  } sb_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  sb_t         sbq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        prev_done = 1'b0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Scoreboard: every done pulse pops one expected result and checks latency
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && bus.done) begin
      check("done_single_cycle", {31'b0, prev_done}, 32'd0);
      check("busy_with_done", {31'b0, bus.busy}, 32'd0);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result %h want no done", bus.result);
      end else begin
        e = sbq.pop_front();
        check(e.name, bus.result, e.exp);
        check({e.name, "_latency"}, cyc - e.acc, 32'd33);
        last_res = bus.result;
      end
    end
    prev_done <= rst_n & bus.done;
  end

  // Drive a start at the current negedge; accepted at the following posedge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name, input bit track);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (track) sbq.push_back('{exp: exp, acc: cyc, name: name});
    check({name, "_busy"}, {31'b0, bus.busy}, 32'd1);
  endtask

  // Returns at the negedge inside the done cycle
  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done want done within 40 cycles", name);
    end
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
  endtask

  vec_t vt[19];
  int   seen;

  initial begin
    vt[0]  = '{3'd0, 32'd7,        32'd6,        32'd42,       "mul_7x6"};
    vt[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1xm1"};
    vt[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max"};
    vt[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "mulhsu_m1x2"};
    vt[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2"};
    vt[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2"};
    vt[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       "divu_100_7"};
    vt[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        "remu_100_7"};
    vt[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, "div_5_0"};
    vt[9]  = '{3'd7, 32'd5,        32'd0,        32'd5,        "remu_5_0"};
    vt[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"};
    vt[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf"};
    vt[12] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_m1xm1"};
    vt[13] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min"};
    vt[14] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, "div_7_m2"};
    vt[15] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001, "rem_7_m2"};
    vt[16] = '{3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, "rem_m7_0"};
    vt[17] = '{3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, "divu_max_1"};
    vt[18] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "mulhsu_min"};

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset, then idle outputs for 10 cycles
    repeat (3) @(negedge clk);
    check("rst_flags", {30'b0, bus.busy, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_flags", {30'b0, bus.busy, bus.done}, 32'd0);
      check("idle_result", bus.result, 32'd0);
    end

    // Vector table: first from IDLE, the rest back-to-back on the done cycle
    for (int i = 0; i < 19; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].name, 1'b1);
      wait_done(vt[i].name);
    end
    repeat (3) @(negedge clk);

    // start during CALC must be ignored
    issue(3'd0, 32'd1234, 32'd5678, 32'd7006652, "mul_ignore", 1'b1);
    repeat (10) @(negedge clk);
    bus.op    = 3'd4;
    bus.a     = 32'd100;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("mul_ignore");
    count_done(40, seen);
    check("ignore_single_done", seen, 32'd0);

    // flush mid-CALC: busy drops, no done, result kept
    @(negedge clk);
    issue(3'd5, 32'd1000, 32'd3, 32'd0, "flush_op", 1'b0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy", {31'b0, bus.busy}, 32'd0);
    count_done(40, seen);
    check("flush_no_done", seen, 32'd0);
    check("flush_result", bus.result, last_res);

    // reset mid-CALC: outputs clear immediately, no done afterwards
    @(negedge clk);
    issue(3'd3, 32'hFFFFFFFF, 32'd3, 32'd0, "reset_op", 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_flags", {30'b0, bus.busy, bus.done}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(40, seen);
    check("arst_no_done", seen, 32'd0);

    // flush with start in IDLE drops the start
    @(negedge clk);
    bus.op    = 3'd0;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    bus.flush = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_idle_busy", {31'b0, bus.busy}, 32'd0);
    count_done(40, seen);
    check("flush_idle_no_done", seen, 32'd0);

    // flush with start in DONE: done still shows, start dropped
    @(negedge clk);
    issue(3'd0, 32'd3, 32'd4, 32'd12, "mul_3x4", 1'b1);
    wait_done("mul_3x4");
    bus.op    = 3'd0;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    bus.flush = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_done_busy", {31'b0, bus.busy}, 32'd0);
    count_done(40, seen);
    check("flush_done_no_done", seen, 32'd0);
    check("flush_done_result", bus.result, 32'd12);

    check("scoreboard_empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
